// File: rtl/uart_tx_sched.sv
// Round-robin two-port transmit scheduler feeding a single-byte uart_tx.
// Times each frame internally because uart_tx exposes no busy indication.
module uart_tx_sched #(
    parameter int DEPTH_LOG2   = 2,
    parameter int FRAME_CYCLES = 52090
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [7:0]            req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [7:0]            req1_data,
    output logic                  req1_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   fifo_level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(FRAME_CYCLES + 1);
    localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]       L_FRAME = TW'(FRAME_CYCLES);

    typedef enum logic { S_IDLE, S_SEND } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_last;
    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;

    logic       w_full;
    logic       w_empty;
    logic       w_grant;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_push_data;

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    // Contention goes to the port not served last; otherwise whoever is valid.
    assign w_grant     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
    assign req0_ready  = !w_grant && !w_full;
    assign req1_ready  = w_grant && !w_full;
    assign w_push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_push_data = w_grant ? req1_data : req0_data;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_last   <= w_grant;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Reset lands in SEND so a frame cut short by reset can finish on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_SEND;
            r_timer    <= L_FRAME;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_tx_data  <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_timer    <= L_FRAME;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    r_timer <= r_timer - 1'b1;
                    if (r_timer == TW'(1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = !w_empty || (r_state == S_SEND);
    assign fifo_level = r_count;
endmodule
